// File: rtl/lcd_reader_pkg.sv
// Shared LCD1602 definitions: read-FSM states, bus constants, default timing.
// No logic of its own; no latency.
// No flow control; constants only.
package lcd_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EN_HI,
    ST_EN_LO,
    ST_DONE
  } lcd_rd_state_t;

  // Busy flag position in a BF/AC read, and RS encodings
  localparam int   LCD_BF_BIT   = 7;
  localparam logic LCD_RS_INSTR = 1'b0;
  localparam logic LCD_RS_DATA  = 1'b1;

  // Default bus timing in clock cycles, shared with the write path
  localparam int LCD_T_SETUP_DEF  = 2;
  localparam int LCD_T_EN_DEF     = 16;
  localparam int LCD_T_GAP_DEF    = 16;
  localparam int LCD_MAX_POLL_DEF = 1000;

  // Width of a down-counter that must hold (max phase length - 1)
  function automatic int phase_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/lcd_reader_if.sv
// Request/response and LCD pin bundle for the read controller.
// Wires only; no latency.
// Requests are accepted only while oBusy is low; there is no queuing.
interface lcd_reader_if;
  logic       iReq;
  logic       iRS;
  logic       iPoll;
  logic [7:0] iLCD_DATA;
  logic       oBusy;
  logic       oDone;
  logic [7:0] oData;
  logic       oTimeout;
  logic       LCD_RS;
  logic       LCD_RW;
  logic       LCD_EN;

  // Requester side: issues reads, presents the pin data, watches results
  modport master (
    output iReq, iRS, iPoll, iLCD_DATA,
    input  oBusy, oDone, oData, oTimeout, LCD_RS, LCD_RW, LCD_EN
  );

  // Reader side
  modport slave (
    input  iReq, iRS, iPoll, iLCD_DATA,
    output oBusy, oDone, oData, oTimeout, LCD_RS, LCD_RW, LCD_EN
  );
endinterface

// File: rtl/lcd_reader_phase_timer.sv
// Loadable down-counter timing one bus phase; tc is high while the count is zero.
// A load of N-1 gives a phase of N cycles; tc is combinational from the count.
// No backpressure; load overrides counting.
module lcd_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Reload on phase entry, otherwise count down and hold at zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780 read controller: single BF/AC or data read, or busy-flag polling.
// oDone T_SETUP+T_EN+T_GAP+1 cycles after acceptance (n reads: n*(sum)+1).
// iReq is ignored while oBusy is high; no queuing.
module lcd_reader
  import lcd_reader_pkg::*;
#(
  parameter int T_SETUP  = LCD_T_SETUP_DEF,
  parameter int T_EN     = LCD_T_EN_DEF,
  parameter int T_GAP    = LCD_T_GAP_DEF,
  parameter int MAX_POLL = LCD_MAX_POLL_DEF
) (
  input logic         iCLK,
  input logic         iRST_N,
  lcd_reader_if.slave lcd
);

  localparam int PW = phase_width(T_SETUP, T_EN, T_GAP);
  localparam int CW = $clog2(MAX_POLL + 1);

  localparam logic [PW-1:0] LD_SETUP = PW'(T_SETUP - 1);
  localparam logic [PW-1:0] LD_EN    = PW'(T_EN - 1);
  localparam logic [PW-1:0] LD_GAP   = PW'(T_GAP - 1);
  localparam logic [CW-1:0] POLL_LAST = CW'(MAX_POLL - 1);
  localparam logic [CW-1:0] POLL_SAT  = CW'(MAX_POLL);

  lcd_rd_state_t  state;
  logic           poll_mode;
  logic [CW-1:0]  poll_cnt;
  logic           ph_load;
  logic [PW-1:0]  ph_val;
  logic           ph_tc;
  logic           again;

  // Another read is due when polling, the display still reports busy, and reads remain
  assign again = poll_mode && lcd.oData[LCD_BF_BIT] && (poll_cnt < POLL_LAST);

  // Select the phase length to load whenever the FSM enters a timed state
  always_comb begin
    ph_load = 1'b0;
    ph_val  = LD_SETUP;
    unique case (state)
      ST_IDLE: begin
        if (lcd.iReq) begin
          ph_load = 1'b1;
          ph_val  = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (ph_tc) begin
          ph_load = 1'b1;
          ph_val  = LD_EN;
        end
      end
      ST_EN_HI: begin
        if (ph_tc) begin
          ph_load = 1'b1;
          ph_val  = LD_GAP;
        end
      end
      ST_EN_LO: begin
        if (ph_tc) begin
          ph_load = 1'b1;
          ph_val  = LD_SETUP;
        end
      end
      default: ;
    endcase
  end

  lcd_phase_timer #(.W(PW)) u_phase (
    .clk      (iCLK),
    .rst_n    (iRST_N),
    .load     (ph_load),
    .load_val (ph_val),
    .tc       (ph_tc)
  );

  // Read-cycle FSM with registered bus controls, status and poll counter
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state        <= ST_IDLE;
      poll_mode    <= 1'b0;
      poll_cnt     <= '0;
      lcd.oBusy    <= 1'b0;
      lcd.oDone    <= 1'b0;
      lcd.oData    <= 8'h00;
      lcd.oTimeout <= 1'b0;
      lcd.LCD_RS   <= 1'b0;
      lcd.LCD_RW   <= 1'b0;
      lcd.LCD_EN   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          lcd.LCD_RW <= 1'b0;
          lcd.LCD_EN <= 1'b0;
          if (lcd.iReq) begin
            // RS is latched here and only here, so it is stable across the EN pulse
            state      <= ST_SETUP;
            lcd.LCD_RS <= lcd.iRS;
            lcd.LCD_RW <= 1'b1;
            lcd.oBusy  <= 1'b1;
            poll_mode  <= lcd.iPoll && (lcd.iRS == LCD_RS_INSTR);
            poll_cnt   <= '0;
          end
        end
        ST_SETUP: begin
          if (ph_tc) begin
            state      <= ST_EN_HI;
            lcd.LCD_EN <= 1'b1;
          end
        end
        ST_EN_HI: begin
          if (ph_tc) begin
            // Capture on the falling-EN edge, while the LCD still drives the bus
            state      <= ST_EN_LO;
            lcd.LCD_EN <= 1'b0;
            lcd.oData  <= lcd.iLCD_DATA;
          end
        end
        ST_EN_LO: begin
          if (ph_tc) begin
            if (again) begin
              state <= ST_SETUP;
              if (poll_cnt != POLL_SAT) begin
                poll_cnt <= poll_cnt + 1'b1;
              end
            end else begin
              state        <= ST_DONE;
              lcd.LCD_RW   <= 1'b0;
              lcd.oDone    <= 1'b1;
              lcd.oTimeout <= poll_mode && lcd.oData[LCD_BF_BIT];
            end
          end
        end
        ST_DONE: begin
          state        <= ST_IDLE;
          lcd.oDone    <= 1'b0;
          lcd.oTimeout <= 1'b0;
          lcd.oBusy    <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader: per-cycle comparison against a timing model
// plus directed scenarios with literal expectations, then randomized traffic.
module tb_lcd_reader;

  localparam int TS   = 2;
  localparam int TE   = 16;
  localparam int TG   = 16;
  localparam int PER  = TS + TE + TG;
  localparam int MAXP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_reader_if lcd ();

  lcd_reader #(.T_SETUP(TS), .T_EN(TE), .T_GAP(TG), .MAX_POLL(MAXP)) dut (
    .iCLK   (clk),
    .iRST_N (rst_n),
    .lcd    (lcd.slave)
  );

  int checks = 0;
  int errors = 0;
  int done_total = 0;
  logic cmp_on = 1'b0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a transaction is a run of PER-cycle reads counted from acceptance
  logic       m_act = 1'b0, m_fin = 1'b0, m_poll = 1'b0;
  int         m_pos = 0, m_reads = 0;
  logic       e_busy = 0, e_done = 0, e_to = 0, e_rs = 0, e_rw = 0, e_en = 0;
  logic [7:0] e_data = 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_act = 0; m_fin = 0;
      e_busy = 0; e_done = 0; e_to = 0; e_rs = 0; e_rw = 0; e_en = 0; e_data = 8'h00;
    end else if (m_fin) begin
      m_fin = 0; e_done = 0; e_to = 0; e_busy = 0;
    end else if (!m_act) begin
      if (lcd.iReq) begin
        m_act = 1; m_pos = 0; m_reads = 1;
        m_poll = lcd.iPoll && !lcd.iRS;
        e_rs = lcd.iRS; e_rw = 1; e_busy = 1; e_en = 0;
      end
    end else begin
      if (m_pos == TS + TE - 1) e_data = lcd.iLCD_DATA;
      m_pos++;
      if (m_pos == PER) begin
        if (m_poll && e_data[7] && m_reads < MAXP) begin
          m_reads++; m_pos = 0; e_en = 0;
        end else begin
          m_act = 0; m_fin = 1; e_done = 1; e_rw = 0; e_en = 0;
          e_to = m_poll && e_data[7];
        end
      end else begin
        e_en = (m_pos >= TS) && (m_pos < TS + TE);
      end
    end
  end

  // Compare every output against the model on every cycle
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("oBusy",    {7'd0, lcd.oBusy},    {7'd0, e_busy});
      chk("oDone",    {7'd0, lcd.oDone},    {7'd0, e_done});
      chk("oTimeout", {7'd0, lcd.oTimeout}, {7'd0, e_to});
      chk("oData",    lcd.oData,            e_data);
      chk("LCD_RS",   {7'd0, lcd.LCD_RS},   {7'd0, e_rs});
      chk("LCD_RW",   {7'd0, lcd.LCD_RW},   {7'd0, e_rw});
      chk("LCD_EN",   {7'd0, lcd.LCD_EN},   {7'd0, e_en});
      if (lcd.oDone === 1'b1) done_total++;
    end
  end

  // LCD bus emulation: random bytes, or a table indexed by completed EN pulses
  logic [7:0] tbl [4];
  int   bus_mode = 0, falls = 0, tbl_base = 0, idx = 0;
  logic en_seen = 1'b0;
  always @(negedge clk) begin
    if (en_seen && !lcd.LCD_EN) falls++;
    en_seen = lcd.LCD_EN;
    if (bus_mode == 0) begin
      lcd.iLCD_DATA = 8'($urandom);
    end else begin
      idx = falls - tbl_base;
      if (idx > 3) idx = 3;
      lcd.iLCD_DATA = tbl[idx];
    end
  end

  task automatic set_tbl(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
    tbl[0] = a; tbl[1] = b; tbl[2] = c; tbl[3] = d;
    tbl_base = falls;
    bus_mode = 1;
    repeat (2) @(negedge clk);
  endtask

  // One request from IDLE; lat counts cycles from the first SETUP cycle through DONE
  task automatic run_txn(input logic rs, input logic poll, input int pulse_at,
                         output int lat, output int en_cyc, output int rw_cyc,
                         output int pulses, output logic busy_ok);
    logic en_prev;
    lat = 0; en_cyc = 0; rw_cyc = 0; pulses = 0; busy_ok = 1; en_prev = 0;
    @(negedge clk);
    lcd.iReq = 1; lcd.iRS = rs; lcd.iPoll = poll;
    @(negedge clk);
    lcd.iRS = ~rs; lcd.iPoll = ~poll;
    while (lat < 2000) begin
      lat++;
      if (lcd.LCD_EN) en_cyc++;
      if (lcd.LCD_RW) rw_cyc++;
      if (lcd.LCD_EN && !en_prev) pulses++;
      en_prev = lcd.LCD_EN;
      if (!lcd.oBusy) busy_ok = 0;
      lcd.iReq = (lat == pulse_at);
      if (lcd.oDone) break;
      @(negedge clk);
    end
    lcd.iReq = 0;
  endtask

  int lat, en_cyc, rw_cyc, pulses, d0, first_done, second_done, n_done;
  logic busy_ok;

  initial begin
    lcd.iReq = 0; lcd.iRS = 0; lcd.iPoll = 0; lcd.iLCD_DATA = 8'h00;
    rst_n = 0;
    @(posedge clk);
    cmp_on = 1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {7'd0, lcd.oBusy}, 8'h00);
    chk("rst_done", {7'd0, lcd.oDone}, 8'h00);
    chk("rst_data", lcd.oData, 8'h00);
    chk("rst_rw",   {7'd0, lcd.LCD_RW}, 8'h00);
    chk("rst_en",   {7'd0, lcd.LCD_EN}, 8'h00);
    rst_n = 1;
    repeat (2) @(negedge clk);

    // Single data read
    set_tbl(8'h41, 8'h41, 8'h41, 8'h41);
    run_txn(1'b1, 1'b0, 0, lat, en_cyc, rw_cyc, pulses, busy_ok);
    chk("read_latency", 8'(lat), 8'd35);
    chk("read_en_cycles", 8'(en_cyc), 8'd16);
    chk("read_rw_cycles", 8'(rw_cyc), 8'd34);
    chk("read_data", lcd.oData, 8'h41);
    chk("read_timeout", {7'd0, lcd.oTimeout}, 8'h00);
    repeat (3) @(negedge clk);

    // Busy-flag poll that succeeds on the third read
    set_tbl(8'h85, 8'h85, 8'h05, 8'h05);
    run_txn(1'b0, 1'b1, 0, lat, en_cyc, rw_cyc, pulses, busy_ok);
    chk("poll_pulses", 8'(pulses), 8'd3);
    chk("poll_latency", 8'(lat), 8'd103);
    chk("poll_data", lcd.oData, 8'h05);
    chk("poll_timeout", {7'd0, lcd.oTimeout}, 8'h00);
    repeat (3) @(negedge clk);

    // Poll timeout with the display stuck busy
    set_tbl(8'h80, 8'h80, 8'h80, 8'h80);
    run_txn(1'b0, 1'b1, 0, lat, en_cyc, rw_cyc, pulses, busy_ok);
    chk("tmo_pulses", 8'(pulses), 8'd4);
    chk("tmo_latency", 8'(lat), 8'd137);
    chk("tmo_flag", {7'd0, lcd.oTimeout}, 8'h01);
    chk("tmo_data", lcd.oData, 8'h80);
    repeat (3) @(negedge clk);

    // Second request mid-transaction is ignored
    set_tbl(8'h5a, 8'h5a, 8'h5a, 8'h5a);
    d0 = done_total;
    run_txn(1'b1, 1'b0, 10, lat, en_cyc, rw_cyc, pulses, busy_ok);
    chk("ignore_busy_held", {7'd0, busy_ok}, 8'h01);
    chk("ignore_latency", 8'(lat), 8'd35);
    repeat (40) @(negedge clk);
    chk("ignore_one_done", 8'(done_total - d0), 8'd1);

    // Capture happens on the EN fall, not after the bus changes
    set_tbl(8'h12, 8'h34, 8'h34, 8'h34);
    run_txn(1'b1, 1'b0, 0, lat, en_cyc, rw_cyc, pulses, busy_ok);
    chk("capture_edge_data", lcd.oData, 8'h12);
    repeat (3) @(negedge clk);

    // Reset during EN_HI aborts without oDone; the next request runs normally
    set_tbl(8'h77, 8'h77, 8'h77, 8'h77);
    lcd.iReq = 1; lcd.iRS = 1; lcd.iPoll = 0;
    @(negedge clk);
    lcd.iReq = 0;
    repeat (7) @(negedge clk);
    chk("midrst_en_before", {7'd0, lcd.LCD_EN}, 8'h01);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_en",   {7'd0, lcd.LCD_EN}, 8'h00);
    chk("midrst_rw",   {7'd0, lcd.LCD_RW}, 8'h00);
    chk("midrst_busy", {7'd0, lcd.oBusy},  8'h00);
    chk("midrst_data", lcd.oData, 8'h00);
    rst_n = 1;
    d0 = done_total;
    repeat (40) @(negedge clk);
    chk("midrst_no_done", 8'(done_total - d0), 8'd0);
    run_txn(1'b1, 1'b0, 0, lat, en_cyc, rw_cyc, pulses, busy_ok);
    chk("midrst_after_latency", 8'(lat), 8'd35);
    chk("midrst_after_data", lcd.oData, 8'h77);
    repeat (3) @(negedge clk);

    // iReq held high: back-to-back reads separated by one IDLE cycle
    lcd.iReq = 1; lcd.iRS = 1; lcd.iPoll = 0;
    first_done = 0; second_done = 0; n_done = 0;
    for (int i = 1; i <= 75; i++) begin
      @(negedge clk);
      if (lcd.oDone) begin
        n_done++;
        if (n_done == 1) first_done = i;
        if (n_done == 2) second_done = i;
      end
    end
    lcd.iReq = 0;
    chk("b2b_count", 8'(n_done), 8'd2);
    chk("b2b_first", 8'(first_done), 8'd35);
    chk("b2b_spacing", 8'(second_done - first_done), 8'd36);
    repeat (50) @(negedge clk);

    // Randomized traffic with occasional resets, checked cycle by cycle
    bus_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      lcd.iReq  = ($urandom_range(0, 3) == 0);
      lcd.iRS   = 1'($urandom_range(0, 1));
      lcd.iPoll = 1'($urandom_range(0, 1));
      rst_n     = ($urandom_range(0, 599) != 0);
    end
    lcd.iReq = 0;
    rst_n = 1;
    repeat (200) @(negedge clk);
    chk("final_idle", {7'd0, lcd.oBusy}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
